// File: rtl/uart_mmio_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_port_pkg
//  Brief    : Shared status bit positions, register selects and FSM states
//             for the memory-mapped UART port.
//  Revision : 1.0
// ============================================================================
package uart_mmio_port_pkg;

    localparam int   c_st_rxv   = 0;
    localparam int   c_st_txr   = 1;
    localparam int   c_st_ovr   = 2;
    localparam int   c_st_frm   = 3;

    localparam logic c_reg_data = 1'b0;
    localparam logic c_reg_stat = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_port_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Brief    : Free-running mod-DIV counter producing a one-cycle tick.
//  Revision : 1.0
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_cnt <= '0;
        else if (r_cnt == c_last) r_cnt <= '0;
        else                     r_cnt <= r_cnt + 1'b1;
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_mmio_port.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_port
//  Brief    : Memory-mapped 8N1 UART: 16x oversampled RX into a small FIFO,
//             single-byte TX holding register, data/status register decode.
//  Revision : 1.0
// ============================================================================
module uart_mmio_port
    import uart_mmio_port_pkg::*;
#(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD          = 9600,
    parameter int RX_DEPTH_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       rd,
    input  logic       wr,
    input  logic       s_mmio,
    input  logic       s_io,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int c_div   = CLK_FREQ / (BAUD * 16);
    localparam int c_depth = 1 << RX_DEPTH_BITS;
    localparam logic [RX_DEPTH_BITS:0] c_full_cnt = (RX_DEPTH_BITS + 1)'(c_depth);

    logic w_tick;
    logic r_rx_meta, r_rx_sync;
    logic r_rd_q, r_wr_q, r_rd_sel;
    logic w_rd_act, w_wr_act, w_rd_rel, w_wr_rise;
    logic w_pop, w_push, w_full, w_load, w_set_ovr, w_set_frm, w_stat_clr;
    logic r_ovr, r_frm_err;
    logic [7:0] w_status;

    uart_state_t r_rx_state, w_rx_state_nxt;
    logic [3:0]  r_rx_tcnt,  w_rx_tcnt_nxt;
    logic [2:0]  r_rx_bit,   w_rx_bit_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic        w_rx_done;

    logic [7:0]               r_fifo_mem [c_depth];
    logic [RX_DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [RX_DEPTH_BITS:0]   r_count;

    uart_state_t r_tx_state, w_tx_state_nxt;
    logic [3:0]  r_tx_tcnt,  w_tx_tcnt_nxt;
    logic [2:0]  r_tx_bit,   w_tx_bit_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic        w_tx_take;
    logic [7:0]  r_hold;
    logic        r_hold_full;

    uart_baud_tick #(.DIV(c_div)) u_baud (.clk(clk), .rst(rst), .tick(w_tick));

    // Reads act on release so data_out holds still for the whole strobe.
    assign w_rd_act   = rd & s_mmio;
    assign w_wr_act   = wr & s_mmio;
    assign w_rd_rel   = r_rd_q & ~w_rd_act;
    assign w_wr_rise  = w_wr_act & ~r_wr_q;
    assign w_stat_clr = w_rd_rel & (r_rd_sel == c_reg_stat);
    assign w_pop      = w_rd_rel & (r_rd_sel == c_reg_data) & (r_count != '0);
    assign w_load     = w_wr_rise & (s_io == c_reg_data) & ~r_hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rd_q    <= 1'b0;
            r_wr_q    <= 1'b0;
            r_rd_sel  <= c_reg_data;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rd_q    <= w_rd_act;
            r_wr_q    <= w_wr_act;
            if (w_rd_act) r_rd_sel <= s_io;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_tcnt_nxt  = r_rx_tcnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            S_IDLE: if (!r_rx_sync) begin
                w_rx_state_nxt = S_START;
                w_rx_tcnt_nxt  = '0;
            end
            S_START: if (w_tick) begin
                if (r_rx_tcnt == 4'd7) begin
                    w_rx_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                    w_rx_tcnt_nxt  = '0;
                    w_rx_bit_nxt   = '0;
                end else begin
                    w_rx_tcnt_nxt = r_rx_tcnt + 4'd1;
                end
            end
            S_DATA: if (w_tick) begin
                w_rx_tcnt_nxt = r_rx_tcnt + 4'd1;
                if (r_rx_tcnt == 4'd15) begin
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
                end
            end
            S_STOP: if (w_tick) begin
                w_rx_tcnt_nxt = r_rx_tcnt + 4'd1;
                if (r_rx_tcnt == 4'd15) begin
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = S_IDLE;
                end
            end
            default: w_rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_tcnt  <= w_rx_tcnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign w_full    = (r_count == c_full_cnt);
    assign w_push    = w_rx_done & r_rx_sync & (~w_full | w_pop);
    assign w_set_ovr = w_rx_done & r_rx_sync & w_full & ~w_pop;
    assign w_set_frm = w_rx_done & ~r_rx_sync;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= r_rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovr     <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_set_ovr)       r_ovr <= 1'b1;
            else if (w_stat_clr) r_ovr <= 1'b0;
            if (w_set_frm)       r_frm_err <= 1'b1;
            else if (w_stat_clr) r_frm_err <= 1'b0;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_tcnt_nxt  = r_tx_tcnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_take      = 1'b0;
        case (r_tx_state)
            S_IDLE: if (r_hold_full) begin
                w_tx_take      = 1'b1;
                w_tx_shift_nxt = r_hold;
                w_tx_tcnt_nxt  = '0;
                w_tx_state_nxt = S_START;
            end
            S_START: if (w_tick) begin
                w_tx_tcnt_nxt = r_tx_tcnt + 4'd1;
                if (r_tx_tcnt == 4'd15) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = S_DATA;
                end
            end
            S_DATA: if (w_tick) begin
                w_tx_tcnt_nxt = r_tx_tcnt + 4'd1;
                if (r_tx_tcnt == 4'd15) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_state_nxt = S_STOP;
                end
            end
            S_STOP: if (w_tick) begin
                w_tx_tcnt_nxt = r_tx_tcnt + 4'd1;
                if (r_tx_tcnt == 4'd15) w_tx_state_nxt = S_IDLE;
            end
            default: w_tx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= S_IDLE;
            r_tx_tcnt   <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_tcnt  <= w_tx_tcnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            if (w_tx_take) r_hold_full <= 1'b0;
            if (w_load) begin
                r_hold      <= data_in;
                r_hold_full <= 1'b1;
            end
        end
    end

    // Decoded straight from reset-cleared state, so rst forces tx high at once.
    assign tx = (r_tx_state == S_START) ? 1'b0 :
                (r_tx_state == S_DATA)  ? r_tx_shift[0] : 1'b1;

    always_comb begin
        w_status           = 8'h00;
        w_status[c_st_rxv] = (r_count != '0);
        w_status[c_st_txr] = ~r_hold_full;
        w_status[c_st_ovr] = r_ovr;
        w_status[c_st_frm] = r_frm_err;
        data_out = 8'h00;
        if (s_io == c_reg_stat)  data_out = w_status;
        else if (r_count != '0)  data_out = r_fifo_mem[r_rd_ptr];
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_mmio_port
//  Brief    : Directed bench with a queue-based model of the UART registers.
//  Revision : 1.0
// ============================================================================
module tb_uart_mmio_port;
    localparam int c_push_at = 1523;  // 3 clk sync/detect + 8 + 9*16 ticks

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd = 1'b0, wr = 1'b0;
    logic       s_mmio = 1'b0, s_io = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic [7:0] data_out;

    int n_chk = 0, n_fail = 0, cyc = 0;

    logic [7:0] m_q[$];
    bit m_ovr = 0, m_frm = 0, m_txr = 1, m_tx_busy = 0, chk_en = 0;

    uart_mmio_port #(.CLK_FREQ(1600000), .BAUD(10000), .RX_DEPTH_BITS(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .rd(rd), .wr(wr),
        .s_mmio(s_mmio), .s_io(s_io), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Mirrors the baud counter phase: ticks land on edges where cyc%10==0.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_out(input logic sel);
        if (sel) return {4'b0, m_frm, m_ovr, m_txr, m_q.size() != 0};
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    function automatic void m_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)            m_frm = 1;
        else if (m_q.size() < 4) m_q.push_back(b);
        else                     m_ovr = 1;
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model data_out", data_out, m_out(s_io));
            if (!m_tx_busy) chk("model tx idle", tx, 1);
        end
    end

    // Frames start at phase 7 so the mid-start sample of an 80-clk glitch
    // falls just after the line has returned high.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int rel,
                              output int rise_at);
        logic [8:0] fr;
        fr = {b, 1'b0};
        chk_en = 0;
        rise_at = -1;
        do begin @(posedge clk); #1; end while (cyc % 10 != 7);
        for (int i = 0; i < 1600; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (rise_at < 0 && s_io && data_out[0]) rise_at = i;
            if (i == rel) rd = 1'b0;
            if (i < 1440) rx = fr[i / 160];
            else          rx = stop_ok ? 1'b1 : (i < 1540 ? 1'b0 : 1'b1);
        end
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic send_glitch();
        chk_en = 0;
        do begin @(posedge clk); #1; end while (cyc % 10 != 7);
        rx = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (1700) @(posedge clk);
        #1;
        chk_en = 1;
    endtask

    task automatic do_read(input logic sel, input logic [7:0] exp, input string nm);
        @(posedge clk); #1;
        s_mmio = 1'b1; s_io = sel; rd = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk(nm, data_out, exp);
        end
        rd = 1'b0;
        @(posedge clk);
        if (sel) begin m_ovr = 0; m_frm = 0; end
        else if (m_q.size() != 0) void'(m_q.pop_front());
        #1;
        s_mmio = 1'b0; s_io = 1'b1;
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : stim
        int rise, c, d, len;
        logic [7:0] tb_byte, vals[5];
        logic exp_tx;

        // Reset state, visible with no clock edge
        #1;
        chk("reset tx", tx, 1);
        chk("reset status", data_out, 8'h02);
        s_io = 1'b0; #1;
        chk("reset data", data_out, 8'h00);
        s_io = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; chk_en = 1;

        // Single received byte
        send_frame(8'hA5, 1, -1, rise);
        chk("rx push cycle", rise, c_push_at);
        m_rx(8'hA5, 1); chk_en = 1;
        chk("status after rx", data_out, 8'h03);
        do_read(1'b0, 8'hA5, "read A5 held");
        chk("status after pop", data_out, 8'h02);

        // TX: one frame per write strobe however long it is held
        tb_byte = 8'h3C;
        @(posedge clk); #1;
        s_mmio = 1'b1; s_io = 1'b0; data_in = tb_byte; wr = 1'b1;
        @(posedge clk);
        m_txr = 0; m_tx_busy = 1;
        #1; s_io = 1'b1; #1;
        chk("tx idle at load", tx, 1);
        chk("tx_ready cleared", data_out, 8'h00);
        @(posedge clk);
        m_txr = 1;
        #1;
        c = cyc;
        d = (c % 10 == 0) ? 10 : 10 - (c % 10);
        len = d + 150;
        chk("tx_ready back", data_out, 8'h02);
        for (int j = 0; j < 1640; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (j == 18) begin wr = 1'b0; s_mmio = 1'b0; end
            if (j < len)             exp_tx = 1'b0;
            else if (j < len + 1280) exp_tx = tb_byte[(j - len) / 160];
            else                     exp_tx = 1'b1;
            if (j >= len + 1440) m_tx_busy = 0;
            chk("tx frame bit", tx, exp_tx);
        end

        // Overrun with a 4-deep FIFO
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1, -1, rise);
            m_rx(8'(v), 1);
        end
        chk_en = 1;
        chk("status full+ovr", data_out, 8'h07);
        vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        for (int v = 0; v < 5; v++) do_read(1'b0, vals[v], "overrun read");
        do_read(1'b1, 8'h06, "ovr status read");
        chk("ovr cleared", data_out, 8'h02);

        // Framing error and start-bit glitch
        send_frame(8'h55, 0, -1, rise);
        m_rx(8'h55, 0); chk_en = 1;
        chk("frm set", data_out, 8'h0A);
        send_glitch();
        chk("glitch ignored", data_out, 8'h0A);
        do_read(1'b1, 8'h0A, "frm status read");
        chk("frm cleared", data_out, 8'h02);

        // Push and pop on the same edge with a full FIFO
        for (int v = 0; v < 4; v++) begin
            send_frame(8'h11 + 8'(v), 1, -1, rise);
            m_rx(8'h11 + 8'(v), 1);
        end
        chk_en = 1;
        chk("status full", data_out, 8'h03);
        @(posedge clk); #1;
        s_mmio = 1'b1; s_io = 1'b0; rd = 1'b1;
        #1;
        chk("head before race", data_out, 8'h11);
        send_frame(8'h15, 1, c_push_at - 1, rise);
        void'(m_q.pop_front());
        m_q.push_back(8'h15);
        s_mmio = 1'b0; s_io = 1'b1; #1;
        chk_en = 1;
        chk("full no ovr", data_out, 8'h03);
        vals = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h00};
        for (int v = 0; v < 5; v++) do_read(1'b0, vals[v], "race order read");

        // Reset mid-frame with FIFO data and a sticky flag present
        send_frame(8'h55, 0, -1, rise);
        m_rx(8'h55, 0);
        send_frame(8'h7E, 1, -1, rise);
        m_rx(8'h7E, 1); chk_en = 1;
        @(posedge clk); #1;
        s_mmio = 1'b1; s_io = 1'b0; data_in = 8'h00; wr = 1'b1;
        @(posedge clk);
        m_txr = 0; m_tx_busy = 1;
        #1; wr = 1'b0; s_mmio = 1'b0; s_io = 1'b1;
        @(posedge clk);
        m_txr = 1;
        repeat (300) @(posedge clk);
        #1;
        chk("pre-reset status", data_out, 8'h0B);
        chk("pre-reset tx low", tx, 0);
        @(negedge clk); #2;
        rst = 1'b1; chk_en = 0;
        #1;
        chk("async reset tx", tx, 1);
        chk("async reset status", data_out, 8'h02);
        s_io = 1'b0; #1;
        chk("async reset data", data_out, 8'h00);
        s_io = 1'b1;
        m_q.delete(); m_ovr = 0; m_frm = 0; m_txr = 1; m_tx_busy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; chk_en = 1;
        repeat (50) @(posedge clk);
        #1;
        chk("post-reset status", data_out, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
